// File: rtl/ws2812b_pkg.sv
// Shared WS2812B definitions: bit timing in ns, GRB channel codes, sequencer
// states and the ns-to-cycles conversion also used by the receive-side decoder.
package ws2812b_pkg;

    localparam int T0H_NS  = 400;
    localparam int T1H_NS  = 800;
    localparam int TBIT_NS = 1250;

    localparam logic [1:0] CH_G = 2'd0;
    localparam logic [1:0] CH_R = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SEND  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_LATCH = 3'd5
    } seq_state_t;

    // Round-to-nearest conversion of a duration in ns to clock cycles.
    function automatic int ns_to_cycles(input longint clk_hz, input longint ns);
        return int'((clk_hz * ns + 64'sd500000000) / 64'sd1000000000);
    endfunction

endpackage

// File: rtl/ws2812b_frame_sequencer_bit_encoder.sv
// WS2812B bit encoder: one-byte holding register in front of an MSB-first
// shift register so consecutive bytes leave back-to-back without a gap.
module ws2812b_bit_encoder #(
    parameter int T0H_CYC  = 26,
    parameter int T1H_CYC  = 51,
    parameter int TBIT_CYC = 80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       idle,
    output logic       dout
);

    localparam int PW = $clog2(TBIT_CYC);

    logic [7:0]    hold_r;
    logic          hold_vld_r;
    logic [7:0]    shift_r;
    logic          active_r;
    logic [2:0]    bit_r;
    logic [PW-1:0] phase_r;
    logic          dout_r;

    logic          bit_end_s;
    logic          byte_end_s;
    logic          need_s;
    logic          from_hold_s;
    logic          direct_s;
    logic          fill_s;
    logic [PW-1:0] th_s;

    assign bit_end_s   = active_r && (phase_r == PW'(TBIT_CYC - 1));
    assign byte_end_s  = bit_end_s && (bit_r == 3'd7);
    assign need_s      = !active_r || byte_end_s;
    // An idle engine takes the offered byte straight into the shifter.
    assign from_hold_s = need_s && hold_vld_r;
    assign direct_s    = need_s && !hold_vld_r && byte_valid;
    assign fill_s      = byte_valid && !hold_vld_r && !need_s;
    assign th_s        = shift_r[7] ? PW'(T1H_CYC) : PW'(T0H_CYC);

    assign byte_ready = !hold_vld_r;
    assign idle       = !active_r && !hold_vld_r;
    assign dout       = dout_r;

    // Holding register, shifter and bit-phase counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_r     <= 8'h00;
            hold_vld_r <= 1'b0;
            shift_r    <= 8'h00;
            active_r   <= 1'b0;
            bit_r      <= 3'd0;
            phase_r    <= '0;
            dout_r     <= 1'b0;
        end else begin
            if (from_hold_s) begin
                hold_vld_r <= 1'b0;
            end else if (fill_s) begin
                hold_r     <= byte_data;
                hold_vld_r <= 1'b1;
            end

            if (from_hold_s || direct_s) begin
                shift_r  <= from_hold_s ? hold_r : byte_data;
                active_r <= 1'b1;
                bit_r    <= 3'd0;
                phase_r  <= '0;
                dout_r   <= 1'b1;
            end else if (byte_end_s) begin
                active_r <= 1'b0;
                phase_r  <= '0;
                dout_r   <= 1'b0;
            end else if (bit_end_s) begin
                shift_r <= {shift_r[6:0], 1'b0};
                bit_r   <= bit_r + 3'd1;
                phase_r <= '0;
                dout_r  <= 1'b1;
            end else if (active_r) begin
                phase_r <= phase_r + PW'(1);
                dout_r  <= (phase_r + PW'(1)) < th_s;
            end else begin
                dout_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ws2812b_frame_sequencer.sv
// WS2812B frame sequencer: GRB pixel buffer streamed through the bit encoder,
// followed by a latch-low period. WS2812B_SEQ_LOOP_EN adds a 'loop' input for
// back-to-back frames.
module ws2812b_frame_sequencer
    import ws2812b_pkg::*;
#(
    parameter int CLK_HZ     = 64000000,
    parameter int NUM_PIXELS = 8,
    parameter int RESET_US   = 60
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wr_en,
    input  logic [$clog2(NUM_PIXELS)-1:0]   wr_pixel,
    input  logic [1:0]                      wr_chan,
    input  logic [7:0]                      wr_data,
    input  logic [$clog2(NUM_PIXELS+1)-1:0] pix_count,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            dout
`ifdef WS2812B_SEQ_LOOP_EN
    ,
    input  logic                            loop
`endif
);

    localparam int NBYTES       = 3 * NUM_PIXELS;
    localparam int AW           = $clog2(NBYTES);
    localparam int IW           = $clog2(NBYTES + 1);
    localparam int CW           = $clog2(NUM_PIXELS + 1);
    localparam int T0H_CYC      = ns_to_cycles(longint'(CLK_HZ), longint'(T0H_NS));
    localparam int T1H_CYC      = ns_to_cycles(longint'(CLK_HZ), longint'(T1H_NS));
    localparam int TBIT_CYC     = ns_to_cycles(longint'(CLK_HZ), longint'(TBIT_NS));
    localparam int RESET_CYCLES = int'((longint'(CLK_HZ) / 64'sd1000000) * longint'(RESET_US));
    localparam int LW           = $clog2(RESET_CYCLES);

    logic [7:0]    mem [NBYTES];
    seq_state_t    state_r;
    seq_state_t    state_s;
    logic          busy_r;
    logic          done_r;
    logic          busy_s;
    logic          done_s;
    logic [IW-1:0] idx_r;
    logic [IW-1:0] total_r;
    logic [LW-1:0] latch_cnt_r;
    logic [CW-1:0] count_s;
    logic [AW-1:0] waddr_s;
    logic          chan_ok_s;
    logic [7:0]    byte_data_s;
    logic          byte_valid_s;
    logic          byte_ready_s;
    logic          enc_idle_s;
    logic          loop_s;

`ifdef WS2812B_SEQ_LOOP_EN
    assign loop_s = loop;
`else
    assign loop_s = 1'b0;
`endif

    assign count_s     = (pix_count > CW'(NUM_PIXELS)) ? CW'(NUM_PIXELS) : pix_count;
    assign waddr_s     = AW'(wr_pixel) * AW'(3) + AW'(wr_chan);
    assign chan_ok_s   = (wr_chan == CH_G) || (wr_chan == CH_R) || (wr_chan == CH_B);
    assign byte_data_s = mem[idx_r[AW-1:0]];
    assign busy_s      = (state_s != ST_IDLE);

    assign busy = busy_r;
    assign done = done_r;

    // Pixel buffer; deliberately not reset so contents survive a frame abort.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_r && chan_ok_s) begin
            mem[waddr_s] <= wr_data;
        end
    end

    // State register with registered busy/done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Byte index and latch-period counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r       <= '0;
            total_r     <= '0;
            latch_cnt_r <= '0;
        end else begin
            if (state_r == ST_LOAD) begin
                idx_r   <= '0;
                total_r <= IW'(count_s) * IW'(3);
            end else if (byte_valid_s && byte_ready_s && (idx_r < total_r)) begin
                idx_r <= idx_r + IW'(1);
            end
            if (state_r == ST_LATCH) begin
                latch_cnt_r <= latch_cnt_r + LW'(1);
            end else begin
                latch_cnt_r <= '0;
            end
        end
    end

    // Next-state logic. LATCH starts one cycle after the encoder goes idle,
    // so ending at RESET_CYCLES-2 lands done exactly RESET_CYCLES after the
    // final bit period; the done cycle itself refuses a new start.
    always_comb begin
        state_s      = state_r;
        byte_valid_s = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !done_r) state_s = ST_LOAD;
                else                  state_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (count_s == '0) state_s = ST_LATCH;
                else               state_s = ST_SEND;
            end
            ST_SEND: begin
                byte_valid_s = 1'b1;
                if (byte_ready_s) state_s = ST_WAIT;
                else              state_s = ST_SEND;
            end
            ST_WAIT: begin
                if (idx_r >= total_r)  state_s = ST_DRAIN;
                else if (byte_ready_s) state_s = ST_SEND;
                else                   state_s = ST_WAIT;
            end
            ST_DRAIN: begin
                if (enc_idle_s) state_s = ST_LATCH;
                else            state_s = ST_DRAIN;
            end
            ST_LATCH: begin
                if (latch_cnt_r == LW'(RESET_CYCLES - 2)) begin
                    done_s  = 1'b1;
                    state_s = loop_s ? ST_LOAD : ST_IDLE;
                end else begin
                    state_s = ST_LATCH;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    ws2812b_bit_encoder #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .TBIT_CYC(TBIT_CYC)
    ) u_enc (
        .clk       (clk),
        .reset     (reset),
        .byte_valid(byte_valid_s),
        .byte_data (byte_data_s),
        .byte_ready(byte_ready_s),
        .idle      (enc_idle_s),
        .dout      (dout)
    );

endmodule

// File: tb/tb_ws2812b_frame_sequencer.sv
// Directed bench for ws2812b_frame_sequencer at default parameters (64 MHz):
// pulse widths, bit period, latency, latch timing, clamp, busy gating, reset abort.
module tb_ws2812b_frame_sequencer;

    localparam int T0H  = 26;
    localparam int T1H  = 51;
    localparam int TBIT = 80;
    localparam int RST  = 3840;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_pixel = 3'd0;
    logic [1:0] wr_chan = 2'd0;
    logic [7:0] wr_data = 8'h00;
    logic [3:0] pix_count = 4'd0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic       dout;
`ifdef WS2812B_SEQ_LOOP_EN
    logic       loop = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int widths[$];
    int rises[$];
    int hi_w = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int done_busy = 0;
    logic dout_prev = 1'b0;
    logic [7:0] model_mem [24];

    ws2812b_frame_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_pixel (wr_pixel),
        .wr_chan  (wr_chan),
        .wr_data  (wr_data),
        .pix_count(pix_count),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .dout     (dout)
`ifdef WS2812B_SEQ_LOOP_EN
        ,
        .loop     (loop)
`endif
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Pulse/done monitor, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (dout && !dout_prev) begin
            rises.push_back(cyc);
            hi_w = 1;
        end else if (dout) begin
            hi_w++;
        end
        if (!dout && dout_prev) widths.push_back(hi_w);
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = int'(busy);
        end
        dout_prev = dout;
    end

    task automatic check_val(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic wr(input int pix, input int ch, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_pixel = 3'(pix); wr_chan = 2'(ch); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        model_mem[pix*3+ch] = d;
    endtask

    task automatic verify_frame(input string tag, input int wbase, input int rbase,
                                input int nbytes, input int c0);
        int nw, nr, nbad, pbad, k;
        logic [7:0] bv;
        nw = widths.size() - wbase;
        nr = rises.size() - rbase;
        nbad = 0;
        pbad = 0;
        check_val({tag, "_pulses"}, nw, nbytes * 8);
        for (int i = 0; i < nw && i < nbytes * 8; i++) begin
            k  = i / 8;
            bv = model_mem[k];
            if (widths[wbase+i] != (bv[7 - (i % 8)] ? T1H : T0H)) nbad++;
        end
        check_val({tag, "_widths_bad"}, nbad, 0);
        for (int i = 1; i < nr; i++) begin
            if (rises[rbase+i] - rises[rbase+i-1] != TBIT) pbad++;
        end
        check_val({tag, "_periods_bad"}, pbad, 0);
        if (nr > 0) begin
            check_val({tag, "_first_rise"}, rises[rbase] - c0, 3);
            check_val({tag, "_done_delay"}, done_cyc - (rises[rbase+nr-1] + TBIT), RST);
        end
        check_val({tag, "_busy_at_done"}, done_busy, 0);
    endtask

    task automatic run_frame(input string tag, input int pc, input int nbytes,
                             input bit wr_with_start, input logic [7:0] wdat, input bit mid);
        int wbase, rbase, dbase, c0, got;
        wbase = widths.size();
        rbase = rises.size();
        dbase = done_cnt;
        @(negedge clk);
        pix_count = 4'(pc);
        start = 1'b1;
        c0 = cyc;
        if (wr_with_start) begin
            wr_en = 1'b1; wr_pixel = 3'd7; wr_chan = 2'd2; wr_data = wdat;
            model_mem[23] = wdat;
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        check_val({tag, "_busy_rise"}, int'(busy), 1);
        got = 0;
        for (int n = 0; n < 25000; n++) begin
            if (done) begin
                got = 1;
                break;
            end
            if (mid && n == 300) begin
                wr_en = 1'b1; wr_pixel = 3'd0; wr_chan = 2'd0; wr_data = 8'hFF; start = 1'b1;
            end else if (mid && n == 301) begin
                wr_en = 1'b0; start = 1'b0;
            end
            @(negedge clk);
        end
        check_val({tag, "_done_seen"}, got, 1);
        @(negedge clk);
        check_val({tag, "_done_count"}, done_cnt - dbase, 1);
        verify_frame(tag, wbase, rbase, nbytes, c0);
    endtask

    initial begin
        int r0, d0, blen, got, gaps, ndone;
        for (int i = 0; i < 24; i++) model_mem[i] = 8'h00;

        repeat (4) @(negedge clk);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_dout", int'(dout), 0);
        reset = 1'b0;

        // One pixel G=0x80 R=0x01 B=0x00.
        wr(0, 0, 8'h80);
        wr(0, 1, 8'h01);
        wr(0, 2, 8'h00);
        run_frame("t1", 1, 3, 1'b0, 8'h00, 1'b0);

        // Zero pixels: latch only; start in the done cycle ignored, next one taken.
        r0 = rises.size();
        d0 = done_cnt;
        @(negedge clk);
        pix_count = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        blen = 0;
        got = 0;
        for (int n = 0; n < 5000; n++) begin
            if (done) begin
                got = 1;
                break;
            end
            if (busy) blen++;
            @(negedge clk);
        end
        check_val("t2_done_seen", got, 1);
        check_val("t2_busy_len_ok", int'(blen >= RST && blen <= RST + 2), 1);
        start = 1'b1;
        @(negedge clk);
        check_val("t2_start_on_done_ignored", int'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        check_val("t2_start_after_done_taken", int'(busy), 1);
        check_val("t2_no_pulses", rises.size() - r0, 0);
        check_val("t2_one_done", done_cnt - d0, 1);
        got = 0;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            if (!busy) begin
                got = 1;
                break;
            end
        end
        check_val("t2_second_frame_end", got, 1);

        // Clamp: pix_count=9 sends all 8 pixels; last write coincides with start.
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < 3; c++) begin
                if (!(p == 7 && c == 2)) wr(p, c, 8'(p * 37 + c * 11 + 1));
            end
        end
        run_frame("t3", 9, 24, 1'b1, 8'hC6, 1'b0);

        // Writes and start during a frame are ignored.
        wr(0, 0, 8'h5A);
        wr(0, 1, 8'hC3);
        wr(0, 2, 8'h0F);
        run_frame("t4", 1, 3, 1'b0, 8'h00, 1'b1);
        r0 = rises.size();
        d0 = done_cnt;
        repeat (300) @(negedge clk);
        check_val("t4_no_second_frame", rises.size() - r0, 0);
        check_val("t4_idle_busy", int'(busy), 0);
        check_val("t4_no_extra_done", done_cnt - d0, 0);

        // Reset during bit 5 aborts the frame without done.
        r0 = rises.size();
        @(negedge clk);
        pix_count = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (rises.size() - r0 >= 6) begin
                got = 1;
                break;
            end
        end
        check_val("t5_reached_bit5", got, 1);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("t5_dout_after_reset", int'(dout), 0);
        check_val("t5_busy_after_reset", int'(busy), 0);
        repeat (100) @(negedge clk);
        check_val("t5_no_done", done_cnt - d0, 0);
        check_val("t5_dout_quiet", int'(dout), 0);
        run_frame("t5b", 1, 3, 1'b0, 8'h00, 1'b0);

`ifdef WS2812B_SEQ_LOOP_EN
        // Looping: three frames, busy never drops until the last done.
        loop = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        pix_count = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        gaps = 0;
        ndone = 0;
        for (int n = 0; n < 15000; n++) begin
            if (done) ndone++;
            if (ndone < 3 && !busy) gaps++;
            if (ndone == 2) loop = 1'b0;
            if (ndone == 3) break;
            @(negedge clk);
        end
        check_val("t6_three_dones", ndone, 3);
        check_val("t6_busy_gaps", gaps, 0);
        repeat (100) @(negedge clk);
        check_val("t6_idle_after", int'(busy), 0);
        check_val("t6_done_total", done_cnt - d0, 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
